// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM, GPIO register and free-running cycle counter
// behind a valid/ready request/response pair with one outstanding transaction.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 1,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_we,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   input  logic        rsp_ready,
   output logic [31:0] gpio_out,
   output logic [31:0] cycle_count
);
   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [1:0]  WAIT_INIT = (LATENCY >= 2) ? 2'(LATENCY - 2) : 2'd0;

   typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [1:0]    wait_q, wait_d;
   logic          accept;
   logic          is_misal, is_ram, is_gpio, is_cnt;
   logic          dec_err;
   logic [31:0]   dec_rdata;
   logic [AW-1:0] word_idx;
   logic [31:0]   mem [DEPTH_WORDS];
   logic [31:0]   gpio_q, cnt_q;
   logic [31:0]   rsp_rdata_p0;
   logic          rsp_err_p0, vld_p0;

   assign req_ready = (state_q == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign word_idx  = req_addr[AW+1:2];

   // Address decode; load data comes from storage state ahead of this edge's updates
   always_comb begin
      is_misal  = |req_addr[1:0];
      is_ram    = !is_misal && (req_addr < RAM_BYTES);
      is_gpio   = !is_misal && !is_ram && (req_addr == MMIO_BASE);
      is_cnt    = !is_misal && !is_ram && (req_addr == MMIO_BASE + 32'd4);
      dec_err   = is_misal || (is_cnt && req_we) || !(is_ram || is_gpio || is_cnt);
      dec_rdata = 32'd0;
      if (!req_we && !dec_err) begin
         if (is_ram)
            dec_rdata = mem[word_idx];
         else if (is_gpio)
            dec_rdata = gpio_q;
         else
            dec_rdata = cnt_q;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  wait_d  = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (wait_q == 2'd0)
               state_d = RESP;
            else
               wait_d = wait_q - 2'd1;
         end
         RESP: begin
            if (rsp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Response stage: captured at the accept edge, presented while in RESP
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         wait_q       <= 2'd0;
         vld_p0       <= 1'b0;
         rsp_rdata_p0 <= 32'd0;
         rsp_err_p0   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         vld_p0  <= (state_d == RESP);
         if (accept) begin
            rsp_rdata_p0 <= dec_rdata;
            rsp_err_p0   <= dec_err;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         gpio_q <= 32'd0;
      else if (accept && req_we && is_gpio)
         gpio_q <= req_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= 32'd0;
      else
         cnt_q <= cnt_q + 32'd1;
   end

   // RAM contents survive reset; stores commit at the accept edge
   always_ff @(posedge clk) begin
      if (accept && req_we && is_ram)
         mem[word_idx] <= req_wdata;
   end

   assign rsp_valid   = vld_p0;
   assign rsp_rdata   = rsp_rdata_p0;
   assign rsp_err     = rsp_err_p0;
   assign gpio_out    = gpio_q;
   assign cycle_count = cnt_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 1, 3 and 4.
module tb_data_mem_responder;
   localparam logic [31:0] MB = 32'hFFFF_FF00;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid, req_ready, req_we, rsp_valid, rsp_err, rsp_ready;
   logic [31:0] req_addr [3];
   logic [31:0] req_wdata [3];
   logic [31:0] rsp_rdata [3];
   logic [31:0] gpio_out [3];
   logic [31:0] cycle_count [3];
   logic [31:0] mcnt;
   int          ncmp = 0;
   int          nfail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_responder #(
         .DEPTH_WORDS(256),
         .LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
         .MMIO_BASE(MB)
      ) u_dut (
         .clk(clk), .rst(rst),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]),
         .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_we(req_we[g]),
         .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
         .rsp_ready(rsp_ready[g]),
         .gpio_out(gpio_out[g]), .cycle_count(cycle_count[g])
      );
   end

   // Reference cycle counter
   always @(posedge clk) begin
      if (rst) mcnt <= 32'd0;
      else     mcnt <= mcnt + 32'd1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkb(input string name, input logic act, input logic exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic txn(input int i, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input int hold, output logic [31:0] rd, output logic er, output int lat,
                      output logic [31:0] acc_cnt, output logic [31:0] gpio1);
      @(negedge clk);
      req_addr[i] = addr; req_wdata[i] = wd; req_we[i] = we; req_valid[i] = 1'b1;
      rsp_ready[i] = (hold == 0);
      #1;
      checkb("req_ready_idle", req_ready[i], 1'b1);
      acc_cnt = mcnt;
      @(negedge clk);
      req_valid[i] = 1'b0; req_addr[i] = 32'h0000_0002; req_we[i] = ~we; req_wdata[i] = 32'h0BAD_0BAD;
      gpio1 = gpio_out[i];
      lat = 1;
      rd = 32'hx; er = 1'bx;
      while (!rsp_valid[i] && lat < 12) begin
         checkb("req_ready_busy", req_ready[i], 1'b0);
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid[i]) begin
         ncmp++; nfail++;
         $display("FAIL rsp_timeout: inst %0d rsp_valid still 0 after %0d cycles, required 1", i, lat);
         rsp_ready[i] = 1'b1;
         return;
      end
      checkb("req_ready_resp", req_ready[i], 1'b0);
      rd = rsp_rdata[i]; er = rsp_err[i];
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checkb("hold_valid", rsp_valid[i], 1'b1);
         check("hold_rdata", rsp_rdata[i], rd);
         checkb("hold_err", rsp_err[i], er);
         checkb("hold_ready", req_ready[i], 1'b0);
      end
      rsp_ready[i] = 1'b1;
      @(negedge clk);
      checkb("rsp_drop", rsp_valid[i], 1'b0);
      checkb("ready_back", req_ready[i], 1'b1);
   endtask

   typedef struct {
      int          inst;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
      int          hold;
      logic [31:0] exp_gpio;
   } vec_t;

   vec_t vt [17];

   initial begin
      logic [31:0] rd, ac, gp;
      logic        er;
      int          lat;

      vt[0]  = '{0, 1'b1, 32'h10,        32'hDEADBEEF, 32'h0,        1'b0, 1, 0, 32'h0};
      vt[1]  = '{0, 1'b0, 32'h10,        32'h0,        32'hDEADBEEF, 1'b0, 1, 0, 32'h0};
      vt[2]  = '{0, 1'b1, 32'h4,         32'h11111111, 32'h0,        1'b0, 1, 0, 32'h0};
      vt[3]  = '{0, 1'b0, 32'h2,         32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
      vt[4]  = '{0, 1'b0, 32'h400,       32'h0,        32'h0,        1'b1, 1, 0, 32'h0};
      vt[5]  = '{0, 1'b1, 32'h7,         32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'h0};
      vt[6]  = '{0, 1'b0, 32'h4,         32'h0,        32'h11111111, 1'b0, 1, 0, 32'h0};
      vt[7]  = '{0, 1'b1, 32'h3FC,       32'h12345678, 32'h0,        1'b0, 1, 0, 32'h0};
      vt[8]  = '{0, 1'b0, 32'h3FC,       32'h0,        32'h12345678, 1'b0, 1, 0, 32'h0};
      vt[9]  = '{0, 1'b1, MB,            32'hA5,       32'h0,        1'b0, 1, 0, 32'hA5};
      vt[10] = '{0, 1'b0, MB,            32'h0,        32'hA5,       1'b0, 1, 0, 32'hA5};
      vt[11] = '{0, 1'b1, MB + 32'd4,    32'h5,        32'h0,        1'b1, 1, 0, 32'hA5};
      vt[12] = '{0, 1'b0, 32'hFFFFFF08,  32'h0,        32'h0,        1'b1, 1, 0, 32'hA5};
      vt[13] = '{1, 1'b1, 32'h0,         32'hCAFEF00D, 32'h0,        1'b0, 3, 0, 32'h0};
      vt[14] = '{1, 1'b0, 32'h0,         32'h0,        32'hCAFEF00D, 1'b0, 3, 5, 32'h0};
      vt[15] = '{2, 1'b1, 32'h8,         32'h000055AA, 32'h0,        1'b0, 4, 0, 32'h0};
      vt[16] = '{2, 1'b0, 32'h8,         32'h0,        32'h000055AA, 1'b0, 4, 2, 32'h0};

      rst = 1'b1;
      req_valid = '0; req_we = '0; rsp_ready = '1;
      for (int i = 0; i < 3; i++) begin
         req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
      end
      repeat (3) @(negedge clk);
      checkb("rst_req_ready", req_ready[0], 1'b0);
      checkb("rst_rsp_valid", rsp_valid[0], 1'b0);
      check("rst_rsp_rdata", rsp_rdata[0], 32'h0);
      checkb("rst_rsp_err", rsp_err[0], 1'b0);
      check("rst_gpio", gpio_out[0], 32'h0);
      check("rst_count", cycle_count[0], 32'h0);
      rst = 1'b0;
      @(negedge clk);
      checkb("post_rst_ready", req_ready[2], 1'b1);
      check("count_first", cycle_count[0], 32'h1);

      for (int v = 0; v < 17; v++) begin
         txn(vt[v].inst, vt[v].we, vt[v].addr, vt[v].wdata, vt[v].hold, rd, er, lat, ac, gp);
         check($sformatf("vec%0d_rdata", v), rd, vt[v].exp_rd);
         checkb($sformatf("vec%0d_err", v), er, vt[v].exp_err);
         check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vt[v].exp_lat));
         check($sformatf("vec%0d_gpio", v), gp, vt[v].exp_gpio);
      end

      // Counter load returns the value ahead of the accept edge
      txn(0, 1'b0, MB + 32'd4, 32'h0, 0, rd, er, lat, ac, gp);
      check("cnt_load", rd, ac);
      checkb("cnt_load_err", er, 1'b0);
      txn(0, 1'b1, MB + 32'd4, 32'h0000_0000, 0, rd, er, lat, ac, gp);
      checkb("cnt_store_err", er, 1'b1);
      check("cnt_store_rdata", rd, 32'h0);
      check("cnt_after_store", cycle_count[0], mcnt);

      // Reset during WAIT on the LATENCY=4 instance
      @(negedge clk);
      req_addr[2] = 32'h8; req_we[2] = 1'b0; req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
      @(negedge clk);
      req_valid[2] = 1'b0;
      checkb("wait_no_valid", rsp_valid[2], 1'b0);
      @(negedge clk);
      rst = 1'b1;
      req_addr[1] = 32'h0; req_wdata[1] = 32'h00000BAD; req_we[1] = 1'b1; req_valid[1] = 1'b1;
      #1;
      checkb("rst_blocks_ready", req_ready[1], 1'b0);
      @(negedge clk);
      checkb("rst_drop_valid", rsp_valid[2], 1'b0);
      check("rst_gpio_clear", gpio_out[0], 32'h0);
      check("rst_count_clear", cycle_count[2], 32'h0);
      rst = 1'b0; req_valid[1] = 1'b0;
      #1;
      checkb("ready_after_rst", req_ready[2], 1'b1);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         checkb("no_late_rsp", rsp_valid[2], 1'b0);
         check("count_restart", cycle_count[2], 32'(k));
      end
      txn(2, 1'b0, 32'h8, 32'h0, 0, rd, er, lat, ac, gp);
      check("ram_survives_rst", rd, 32'h000055AA);
      txn(1, 1'b0, 32'h0, 32'h0, 0, rd, er, lat, ac, gp);
      check("rst_store_ignored", rd, 32'hCAFEF00D);

      // Counter wrap via a bench shortcut
      @(negedge clk);
      force g_dut[0].u_dut.cnt_q = 32'hFFFF_FFFE;
      #1;
      release g_dut[0].u_dut.cnt_q;
      @(negedge clk);
      check("wrap_max", cycle_count[0], 32'hFFFF_FFFF);
      @(negedge clk);
      check("wrap_zero", cycle_count[0], 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data-access interface: serves load/store requests over a valid/ready request channel and a valid/ready response channel.
- Contains a word RAM, a writable GPIO output register and a read-only free-running cycle counter.
- Has a configurable response latency and one outstanding transaction.
- Sits between the core's load/store path and on-chip storage; error responses flag misaligned or unmapped accesses.

Parameters:
- DEPTH_WORDS, 256: RAM size in 32-bit words; power of two, 16..4096.
- LATENCY, 1: cycles from request accept edge to rsp_valid high; legal range 1..4.
- MMIO_BASE, 32'hFFFF_FF00: byte address of the GPIO register. The cycle counter sits at MMIO_BASE+4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; combinational, equals (state==IDLE && !rst).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_we  in  1  1 = store, 0 = load.
- rsp_valid  out  1  response present; registered.
- rsp_rdata  out  32  load data; 0 for stores and for errors.
- rsp_err  out  1  access error flag, valid while rsp_valid is high.
- rsp_ready  in  1  requester consumes the response.
- gpio_out  out  32  GPIO register contents.
- cycle_count  out  32  free-running counter value.

Behaviour:
- Reset:
  - state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, gpio_out=0, cycle_count=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. An accept occurs on an edge where req_valid && req_ready.
  - On accept: if LATENCY==1, go to RESP; else go to WAIT with wait counter = LATENCY-2.
  - WAIT: counter decrements each cycle. When it is 0, go to RESP.
  - RESP: rsp_valid=1. Stay until rsp_ready=1; on that edge drop rsp_valid and return to IDLE.
  - rsp_ready high on the first RESP cycle: that edge consumes the response.
  - No accept in the same cycle a response is consumed. Minimum spacing between accepts is LATENCY+1 cycles.
- Accept-edge actions (all at the accept edge):
  - Address, data and decode are captured.
  - Stores commit immediately.
  - Load data is sampled from storage state before that edge's updates, and held in a response register until RESP.
- Decode (checked in order):
  1. req_addr[1:0] != 0: err=1, no side effect.
  2. req_addr < DEPTH_WORDS*4: RAM access; word index = req_addr[log2(DEPTH_WORDS)+1:2].
  3. req_addr == MMIO_BASE: GPIO register, read/write.
  4. req_addr == MMIO_BASE+4: cycle counter. Load returns the counter value before the accept edge's increment. A store gives err=1 and does not modify the counter.
  5. Anything else: err=1.
- Error responses: rsp_rdata=0, no state change other than the FSM.
- Store responses: rsp_rdata=0, rsp_err=0.
- Cycle counter:
  - Increments by 1 every non-reset cycle, independent of the FSM.
  - Wraps from 32'hFFFF_FFFF to 0.
- Request inputs: req_addr, req_wdata and req_we are ignored when no accept occurs. A requester may change them freely while req_ready=0.
- Reset mid-transaction:
  - The FSM returns to IDLE and any pending response is dropped (rsp_valid=0 the cycle after).
  - A store already committed at its accept edge stays committed in RAM; gpio_out is reset to 0.
- rst high with req_valid high: no accept.

Test Plan:
- Store/load, LATENCY=1: store 0xDEADBEEF to 0x10, then load 0x10 with rsp_ready held high -> store response err=0 one cycle after accept; load rsp_rdata=0xDEADBEEF one cycle after its accept; req_ready low exactly one cycle per transaction.
- LATENCY=3 with backpressure: load 0x0 with rsp_ready=0 for 5 cycles -> rsp_valid rises 3 cycles after accept and holds with stable rdata until rsp_ready; req_ready stays 0 throughout.
- MMIO: store 0x000000A5 to MMIO_BASE -> gpio_out=0xA5 the cycle after accept. Load MMIO_BASE+4 accepted at cycle count N -> rdata=N. Store to MMIO_BASE+4 -> err=1 and the counter keeps incrementing.
- Errors: load 0x2 (misaligned), load DEPTH_WORDS*4 (unmapped) and store 0x7 -> err=1, rdata=0; RAM word 1 unchanged after the store to 0x7.
- Reset mid-operation: accept a load at LATENCY=4, assert rst during WAIT -> rsp_valid never rises, req_ready=1 the cycle after rst deasserts, gpio_out=0, cycle_count restarts from 0.
- Counter wrap: force the counter to 0xFFFFFFFE via a long run or a bench shortcut -> the reading after 2 cycles is 0x0.
